clock_set_controller: RTL and testbench



---
 rtl/clock_set_controller.sv | 185 ++++++++++++++++++
 tb/tb_clock_set_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// rtl/clock_set_controller.sv - button front-end for the clock counters: sync, debounce, set-mode FSM, inc pulses, blink
// Optional feature: define CLKSET_AUTOREPEAT_EN to auto-repeat inc pulses while the up button is held.
module clock_set_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int BLINK_HALF      = 6,
  parameter int REPEAT_DELAY    = 8,
  parameter int REPEAT_RATE     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic       run_en,
  output logic       hour_inc,
  output logic       minute_inc,
  output logic [1:0] mode,
  output logic       blink_hour,
  output logic       blink_minute
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    SET_HOUR = 2'b01,
    SET_MIN  = 2'b10
  } state_t;

  state_t state;
  state_t state_next;

  // Index 0 carries the mode button, index 1 the up button.
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    deb;
  logic [1:0]    deb_q;
  logic [DW-1:0] dcnt [2];
  logic [1:0]    press;

  logic          mode_press;
  logic          up_press;
  logic          set_state;
  logic          up_ok;
  logic          rep_fire;
  logic          inc_fire;
  logic          restart;

  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcnt_next;
  logic          phase;
  logic          phase_next;

  assign mode = state;

  // Two-flop synchronizer for both raw buttons.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {btn_up, btn_mode};
      sync2 <= sync1;
    end
  end

  // Debouncer: level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb   <= 2'b00;
      deb_q <= 2'b00;
      for (int i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      deb_q <= deb;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i]  <= ~deb[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  assign press      = deb & ~deb_q;
  assign mode_press = press[0];
  assign up_press   = press[1];
  assign set_state  = (state == SET_HOUR) || (state == SET_MIN);
  // A mode press on the same cycle swallows the up press.
  assign up_ok      = up_press & ~mode_press & set_state;
  assign inc_fire   = up_ok | rep_fire;

`ifdef CLKSET_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic          rep_armed;
  logic          rep_first;
  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_cnt_inc;
  logic [RW-1:0] rep_target;
  logic          rep_hold;

  assign rep_cnt_inc = rep_cnt + RW'(1);
  assign rep_target  = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
  assign rep_hold    = rep_armed & deb[1] & ~mode_press & set_state;
  assign rep_fire    = rep_hold & (rep_cnt_inc == rep_target);

  // Repeat timer: armed by a real press, first gap REPEAT_DELAY, then REPEAT_RATE.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_armed <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (up_ok) begin
      rep_armed <= 1'b1;
      rep_first <= 1'b1;
      rep_cnt   <= '0;
    end else if (rep_fire) begin
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end else if (rep_hold) begin
      rep_cnt   <= rep_cnt_inc;
    end else begin
      rep_armed <= 1'b0;
      rep_first <= 1'b0;
      rep_cnt   <= '0;
    end
  end
`else
  logic unused_repeat_cfg;

  assign rep_fire          = 1'b0;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_RATE)};
`endif

  // Next-state and blink-timer decode feeding the registered outputs.
  always_comb begin
    state_next = state;
    case (state)
      RUN:      if (mode_press) state_next = SET_HOUR;
      SET_HOUR: if (mode_press) state_next = SET_MIN;
      SET_MIN:  if (mode_press) state_next = RUN;
      default:  state_next = RUN;
    endcase

    restart    = (state_next != state) | up_press | rep_fire;
    bcnt_next  = bcnt + BW'(1);
    phase_next = phase;
    if (restart) begin
      bcnt_next  = '0;
      phase_next = 1'b1;
    end else if (bcnt == BW'(BLINK_HALF - 1)) begin
      bcnt_next  = '0;
      phase_next = ~phase;
    end
  end

  // Mode FSM with registered enable, increment pulses and blink flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      run_en       <= 1'b1;
      hour_inc     <= 1'b0;
      minute_inc   <= 1'b0;
      blink_hour   <= 1'b0;
      blink_minute <= 1'b0;
      bcnt         <= '0;
      phase        <= 1'b0;
    end else begin
      state        <= state_next;
      run_en       <= (state_next == RUN);
      hour_inc     <= inc_fire & (state == SET_HOUR);
      minute_inc   <= inc_fire & (state == SET_MIN);
      blink_hour   <= (state_next == SET_HOUR) & phase_next;
      blink_minute <= (state_next == SET_MIN) & phase_next;
      bcnt         <= bcnt_next;
      phase        <= phase_next;
    end
  end

endmodule

// File: tb/tb_clock_set_controller.sv
// tb/tb_clock_set_controller.sv - directed self-checking bench for clock_set_controller
module tb_clock_set_controller;

  logic       clk;
  logic       reset;
  logic       btn_mode;
  logic       btn_up;
  logic       run_en;
  logic       hour_inc;
  logic       minute_inc;
  logic [1:0] mode;
  logic       blink_hour;
  logic       blink_minute;

  int n_checks = 0;
  int n_fail   = 0;
  int hour_cnt = 0;
  int min_cnt  = 0;
  int both_cnt = 0;

  clock_set_controller #(
    .DEBOUNCE_CYCLES(4),
    .BLINK_HALF(6),
    .REPEAT_DELAY(8),
    .REPEAT_RATE(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_up(btn_up),
    .run_en(run_en),
    .hour_inc(hour_inc),
    .minute_inc(minute_inc),
    .mode(mode),
    .blink_hour(blink_hour),
    .blink_minute(blink_minute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally, sampled on the falling edge.
  always @(negedge clk) begin
    if (hour_inc) hour_cnt++;
    if (minute_inc) min_cnt++;
    if (hour_inc && minute_inc) both_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Up press held 7 edges; pulse expected right after the 7th edge.
  task automatic up_press(input int exp_h, input int exp_m);
    btn_up = 1'b1;
    step(6);
    check("inc_before_latency", 32'(hour_inc) + 32'(minute_inc), 0);
    step(1);
    check("hour_inc_pulse", 32'(hour_inc), exp_h);
    check("minute_inc_pulse", 32'(minute_inc), exp_m);
    check("blink_hour_restart", 32'(blink_hour), exp_h);
    check("blink_minute_restart", 32'(blink_minute), exp_m);
    btn_up = 1'b0;
    step(12);
  endtask

  task automatic mode_press(input int exp_mode);
    btn_mode = 1'b1;
    step(7);
    check("mode_after_press", 32'(mode), exp_mode);
    check("run_en_after_press", 32'(run_en), (exp_mode == 0) ? 1 : 0);
    check("blink_hour_after_mode", 32'(blink_hour), (exp_mode == 1) ? 1 : 0);
    check("blink_minute_after_mode", 32'(blink_minute), (exp_mode == 2) ? 1 : 0);
    btn_mode = 1'b0;
    step(12);
  endtask

  initial begin
    int first_t;
    int second_t;
    int base;
    int exp_b;

    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    step(2);
    check("reset_mode", 32'(mode), 0);
    check("reset_run_en", 32'(run_en), 1);
    check("reset_incs", 32'(hour_inc) + 32'(minute_inc), 0);
    check("reset_blinks", 32'(blink_hour) + 32'(blink_minute), 0);
    reset = 1'b0;

    step(50);
    check("idle_mode", 32'(mode), 0);
    check("idle_run_en", 32'(run_en), 1);
    check("idle_blinks", 32'(blink_hour) + 32'(blink_minute), 0);
    check("idle_pulses", hour_cnt + min_cnt, 0);

    // Mode held 10 cycles: SET_HOUR after 7th edge, blink 6 on / 6 off.
    btn_mode = 1'b1;
    for (int t = 1; t <= 19; t++) begin
      step(1);
      exp_b = ((t >= 7 && t <= 12) || t == 19) ? 1 : 0;
      check($sformatf("enter_mode_t%0d", t), 32'(mode), (t >= 7) ? 1 : 0);
      check($sformatf("blink_hour_t%0d", t), 32'(blink_hour), exp_b);
      if (t == 10) btn_mode = 1'b0;
    end
    check("set_hour_run_en", 32'(run_en), 0);
    step(12);

    up_press(1, 0);
    up_press(1, 0);
    up_press(1, 0);
    check("three_hour_pulses", hour_cnt, 3);
    check("no_minute_pulses", min_cnt, 0);

    mode_press(2);
    up_press(0, 1);
    check("hour_after_min_press", hour_cnt, 3);
    check("one_minute_pulse", min_cnt, 1);

    mode_press(0);
    up_press(0, 0);
    check("run_up_hour", hour_cnt, 3);
    check("run_up_minute", min_cnt, 1);
    check("run_up_mode", 32'(mode), 0);

    mode_press(1);
    for (int g = 1; g <= 3; g++) begin
      btn_up = 1'b1;
      step(g);
      btn_up = 1'b0;
      step(10);
    end
    check("glitch_hour", hour_cnt, 3);
    check("glitch_mode", 32'(mode), 1);

    // Mode and up together: mode wins, up discarded.
    btn_mode = 1'b1;
    btn_up   = 1'b1;
    step(7);
    check("simul_mode", 32'(mode), 2);
    check("simul_hour_inc", 32'(hour_inc), 0);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    step(14);
    check("simul_hour_cnt", hour_cnt, 3);
    check("simul_min_cnt", min_cnt, 1);

    // Up held 40 cycles in SET_MIN.
    base     = min_cnt;
    first_t  = 0;
    second_t = 0;
    btn_up   = 1'b1;
    for (int t = 1; t <= 55; t++) begin
      step(1);
      if (minute_inc) begin
        if (first_t == 0) first_t = t;
        else if (second_t == 0) second_t = t;
      end
      if (t == 40) btn_up = 1'b0;
    end
    step(2);
    check("hold_first_pulse", first_t, 7);
`ifdef CLKSET_AUTOREPEAT_EN
    check("hold_second_pulse", second_t, 15);
    check("hold_pulse_count", min_cnt - base, 12);
`else
    check("hold_second_pulse", second_t, 0);
    check("hold_pulse_count", min_cnt - base, 1);
`endif
    check("hold_mode", 32'(mode), 2);

    // Reset lands on the edge that would carry a minute pulse.
    btn_up = 1'b1;
    step(6);
    reset = 1'b1;
    step(1);
    check("midpulse_minute_inc", 32'(minute_inc), 0);
    check("midpulse_mode", 32'(mode), 0);
    check("midpulse_run_en", 32'(run_en), 1);
    check("midpulse_blink_minute", 32'(blink_minute), 0);
    btn_up = 1'b0;
    step(2);

    // Mode button held through reset deassertion: one press at normal latency.
    btn_mode = 1'b1;
    step(2);
    reset = 1'b0;
    step(6);
    check("held_reset_before", 32'(mode), 0);
    step(1);
    check("held_reset_after", 32'(mode), 1);
    step(10);
    check("held_reset_single", 32'(mode), 1);
    btn_mode = 1'b0;
    step(12);

    check("never_both_inc", both_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
